// File: rtl/cam_traffic_gen_if.sv
// CAM request/response, transaction report and status bundle for cam_traffic_gen.
// master = generator side, slave = CAM / observer side.
interface cam_traffic_gen_if #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16
);
  logic             start;
  logic             cam_valid;
  logic             cam_rw_n;
  logic [KEY_W-1:0] cam_key;
  logic [VAL_W-1:0] cam_wdata;
  logic [VAL_W-1:0] cam_rdata;
  logic             cam_rvalid;
  logic             tr_valid;
  logic             tr_rw_n;
  logic [KEY_W-1:0] tr_key;
  logic [VAL_W-1:0] tr_wdata;
  logic [VAL_W-1:0] tr_rdata;
  logic             tr_hit;
  logic             busy;
  logic             done;
  logic [7:0]       err_cnt;

  modport master (
    input  start, cam_rdata, cam_rvalid,
    output cam_valid, cam_rw_n, cam_key, cam_wdata,
    output tr_valid, tr_rw_n, tr_key, tr_wdata, tr_rdata, tr_hit,
    output busy, done, err_cnt
  );

  modport slave (
    output start, cam_rdata, cam_rvalid,
    input  cam_valid, cam_rw_n, cam_key, cam_wdata,
    input  tr_valid, tr_rw_n, tr_key, tr_wdata, tr_rdata, tr_hit,
    input  busy, done, err_cnt
  );
endinterface

// File: rtl/cam_traffic_gen.sv
// CAM traffic generator: fill, overwrite, write-then-read, read-back check and evict phases,
// one report per operation. Macro CAM_TG_RAND_EN adds an unchecked LFSR-driven RAND phase.
module cam_traffic_gen #(
  parameter int               KEY_W    = 16,
  parameter int               VAL_W    = 16,
  parameter int               DEPTH    = 8,
  parameter logic [KEY_W-1:0] BASE_KEY = KEY_W'(16'h0100),
  parameter int               RAND_OPS = 64
) (
  input logic               clk,
  input logic               rst_n,
  cam_traffic_gen_if.master bus
);
  // state | meaning
  // IDLE  | no sequence run since reset, waiting for start
  // FILL  | write BASE_KEY+i with f(key), i = 0..DEPTH-1
  // WW    | write BASE_KEY with 16'h1111, then with f(BASE_KEY)
  // WR    | write BASE_KEY+1, then read it back (checked)
  // HIT   | read BASE_KEY+i, i = 0..DEPTH-1 (checked)
  // EVICT | write BASE_KEY+DEPTH+i, i = 0..DEPTH-1
  // RAND  | RAND_OPS LFSR-driven unchecked ops (CAM_TG_RAND_EN only)
  // DONE  | sequence complete, waiting for start

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WW    = 3'd2,
    WR    = 3'd3,
    HIT   = 3'd4,
    EVICT = 3'd5,
`ifdef CAM_TG_RAND_EN
    RAND  = 3'd6,
`endif
    DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             rw_n;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] wdata;
    logic             chk;
  } op_t;

  function automatic logic [VAL_W-1:0] f_val(input logic [KEY_W-1:0] k);
    logic [31:0] x;
    x = 32'(k) ^ 32'h0000_A5A5;
    return x[VAL_W-1:0];
  endfunction

  function automatic op_t op_wr(input logic [KEY_W-1:0] k, input logic [VAL_W-1:0] d);
    op_t o;
    o.valid = 1'b1;
    o.rw_n  = 1'b0;
    o.key   = k;
    o.wdata = d;
    o.chk   = 1'b0;
    return o;
  endfunction

  function automatic op_t op_rd(input logic [KEY_W-1:0] k);
    op_t o;
    o.valid = 1'b1;
    o.rw_n  = 1'b1;
    o.key   = k;
    o.wdata = '0;
    o.chk   = 1'b1;
    return o;
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  op_t              r_op;
  logic             r_tr_valid;
  logic             r_tr_rw_n;
  logic [KEY_W-1:0] r_tr_key;
  logic [VAL_W-1:0] r_tr_wdata;
  logic [VAL_W-1:0] r_tr_rdata;
  logic             r_tr_hit;
  logic             r_chk_pend;
  logic [VAL_W-1:0] r_chk_exp;
  logic [7:0]       r_err;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic [IDX_W-1:0] w_idx_inc;
  logic [KEY_W-1:0] w_key_b1;
  logic [KEY_W-1:0] w_key_lo_nxt;
  logic [KEY_W-1:0] w_key_ev0;
  logic [KEY_W-1:0] w_key_hi_nxt;
  logic             w_rd_op;
  logic             w_mis;

  assign w_last       = (r_idx == IDX_LAST);
  assign w_idx_inc    = r_idx + IDX_W'(1);
  assign w_key_b1     = BASE_KEY + KEY_W'(1);
  assign w_key_lo_nxt = BASE_KEY + KEY_W'(w_idx_inc);
  assign w_key_ev0    = BASE_KEY + KEY_W'(DEPTH);
  assign w_key_hi_nxt = w_key_ev0 + KEY_W'(w_idx_inc);
  assign w_rd_op      = r_op.valid && r_op.rw_n;
  // r_tr_hit/r_tr_rdata hold the read sample that r_chk_pend refers to.
  assign w_mis        = r_chk_pend && (!r_tr_hit || (r_tr_rdata != r_chk_exp));

`ifdef CAM_TG_RAND_EN
  localparam int RC_W = $clog2(RAND_OPS + 1);

  logic [15:0]     r_lfsr;
  logic [RC_W-1:0] r_rand_cnt;
  logic [15:0]     w_lfsr_nxt;
  logic            w_rand_last;

  assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_rand_last = (r_rand_cnt == '0);

  function automatic op_t op_rand(input logic [15:0] l);
    op_t        o;
    logic [4:0] off;
    off     = {1'b0, l[4:1]} & 5'(2 * DEPTH - 1);
    o.valid = 1'b1;
    o.rw_n  = l[0];
    o.key   = BASE_KEY + KEY_W'(off);
    o.wdata = VAL_W'(l);
    o.chk   = 1'b0;
    return o;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_op       <= '0;
      r_tr_valid <= 1'b0;
      r_tr_rw_n  <= 1'b0;
      r_tr_key   <= '0;
      r_tr_wdata <= '0;
      r_tr_rdata <= '0;
      r_tr_hit   <= 1'b0;
      r_chk_pend <= 1'b0;
      r_chk_exp  <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CAM_TG_RAND_EN
      r_lfsr     <= 16'hACE1;
      r_rand_cnt <= '0;
`endif
    end else begin
      r_tr_valid <= r_op.valid;
      r_tr_rw_n  <= r_op.rw_n;
      r_tr_key   <= r_op.key;
      r_tr_wdata <= r_op.wdata;
      r_tr_rdata <= w_rd_op ? bus.cam_rdata : '0;
      r_tr_hit   <= w_rd_op && bus.cam_rvalid;
      r_chk_pend <= w_rd_op && r_op.chk;
      r_chk_exp  <= f_val(r_op.key);
      if (w_mis && (r_err != 8'hFF)) r_err <= r_err + 8'd1;

      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_op    <= op_wr(BASE_KEY, f_val(BASE_KEY));
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= '0;
          end
        end
        FILL: begin
          if (w_last) begin
            r_state <= WW;
            r_idx   <= '0;
            r_op    <= op_wr(BASE_KEY, VAL_W'(16'h1111));
          end else begin
            r_idx <= w_idx_inc;
            r_op  <= op_wr(w_key_lo_nxt, f_val(w_key_lo_nxt));
          end
        end
        WW: begin
          if (r_idx == '0) begin
            r_idx <= w_idx_inc;
            r_op  <= op_wr(BASE_KEY, f_val(BASE_KEY));
          end else begin
            r_state <= WR;
            r_idx   <= '0;
            r_op    <= op_wr(w_key_b1, f_val(w_key_b1));
          end
        end
        WR: begin
          if (r_idx == '0) begin
            r_idx <= w_idx_inc;
            r_op  <= op_rd(w_key_b1);
          end else begin
            r_state <= HIT;
            r_idx   <= '0;
            r_op    <= op_rd(BASE_KEY);
          end
        end
        HIT: begin
          if (w_last) begin
            r_state <= EVICT;
            r_idx   <= '0;
            r_op    <= op_wr(w_key_ev0, f_val(w_key_ev0));
          end else begin
            r_idx <= w_idx_inc;
            r_op  <= op_rd(w_key_lo_nxt);
          end
        end
        EVICT: begin
          if (w_last) begin
`ifdef CAM_TG_RAND_EN
            r_state    <= RAND;
            r_idx      <= '0;
            r_op       <= op_rand(r_lfsr);
            r_lfsr     <= w_lfsr_nxt;
            r_rand_cnt <= RC_W'(RAND_OPS - 1);
`else
            r_state <= DONE;
            r_idx   <= '0;
            r_op    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_idx <= w_idx_inc;
            r_op  <= op_wr(w_key_hi_nxt, f_val(w_key_hi_nxt));
          end
        end
`ifdef CAM_TG_RAND_EN
        RAND: begin
          if (w_rand_last) begin
            r_state <= DONE;
            r_op    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_op       <= op_rand(r_lfsr);
            r_lfsr     <= w_lfsr_nxt;
            r_rand_cnt <= r_rand_cnt - RC_W'(1);
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_op    <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cam_valid = r_op.valid;
  assign bus.cam_rw_n  = r_op.rw_n;
  assign bus.cam_key   = r_op.key;
  assign bus.cam_wdata = r_op.wdata;
  assign bus.tr_valid  = r_tr_valid;
  assign bus.tr_rw_n   = r_tr_rw_n;
  assign bus.tr_key    = r_tr_key;
  assign bus.tr_wdata  = r_tr_wdata;
  assign bus.tr_rdata  = r_tr_rdata;
  assign bus.tr_hit    = r_tr_hit;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err_cnt   = r_err;
endmodule
